// File: rtl/dpr16x4_pkg.sv
// Shared constants and types for the 16x4 dual-port RAM writer/reader pair.
package dpr16x4_pkg;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned PTR_W  = 5;
  localparam int unsigned ADDR_W = 4;

  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // RAM address is the pointer without its wrap bit.
  function automatic addr_t ptr_addr(input ptr_t p);
    return p[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/dpr16x4_ptr_cmp.sv
// Occupancy compare between the writer and reader pointers of the 16x4 RAM.
module dpr16x4_ptr_cmp
  import dpr16x4_pkg::*;
(
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] level,
  output logic             empty,
  output logic             over_depth
);

  always_comb begin
    level      = wr_ptr - rd_ptr;
    empty      = (wr_ptr == rd_ptr);
    // 17..31 can only arise from a writer that lapped the reader.
    over_depth = (level > ptr_t'(DEPTH));
  end

endmodule

// File: rtl/dpr16x4_reader.sv
// Read side of a 16x4 distributed-RAM FIFO: drives RAD, registers DO into a
// one-word output stage with valid/ready handshake, flush and overrun flag.
module dpr16x4_reader
  import dpr16x4_pkg::*;
#(
  parameter bit ERR_CLR_ON_FLUSH = 1'b1
) (
  input  logic              rck,
  input  logic              rst_n,
  input  logic [PTR_W-1:0]  wr_ptr,
  output logic [ADDR_W-1:0] rad,
  input  logic [DATA_W-1:0] ram_do,
  output logic [PTR_W-1:0]  rd_ptr,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  input  logic              q_ready,
  input  logic              flush,
  output logic [PTR_W-1:0]  level,
  output logic              empty,
  output logic              ovf_err
);

  ptr_t  rd_ptr_q, rd_ptr_d;
  data_t q_q, q_d;
  logic  q_valid_q, q_valid_d;
  logic  ovf_err_q, ovf_err_d;
  logic  over_depth;
  logic  load;

  dpr16x4_ptr_cmp u_ptr_cmp (
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr_q),
    .level      (level),
    .empty      (empty),
    .over_depth (over_depth)
  );

  // Output stage is free when empty or being drained this cycle.
  assign load = !empty && (!q_valid_q || q_ready) && !flush;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    if (flush) begin
      rd_ptr_d  = wr_ptr;
      q_valid_d = 1'b0;
    end else if (load) begin
      q_d       = ram_do;
      q_valid_d = 1'b1;
      rd_ptr_d  = rd_ptr_q + ptr_t'(1);
    end else if (q_valid_q && q_ready) begin
      q_valid_d = 1'b0;
    end
  end

  // Set wins over a flush clear in the same cycle.
  always_comb begin
    ovf_err_d = ovf_err_q;
    if (flush && ERR_CLR_ON_FLUSH) begin
      ovf_err_d = 1'b0;
    end
    if (over_depth) begin
      ovf_err_d = 1'b1;
    end
  end

  always_ff @(posedge rck or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      ovf_err_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  assign rad     = ptr_addr(rd_ptr_q);
  assign rd_ptr  = rd_ptr_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign ovf_err = ovf_err_q;

endmodule

// File: tb/tb_dpr16x4_reader.sv
// Directed bench for dpr16x4_reader; the bench models the writer and the RAM.
module tb_dpr16x4_reader;

  logic       rck = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] wr_ptr = '0;
  logic       q_ready = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] mem [16];

  logic [3:0] rad, ram_do, q;
  logic [4:0] rd_ptr, level;
  logic       q_valid, empty, ovf_err;

  logic [3:0] rad1, ram_do1, q1;
  logic [4:0] rd_ptr1, level1;
  logic       q_valid1, empty1, ovf_err1;

  int checks = 0;
  int errors = 0;

  assign ram_do  = mem[rad];
  assign ram_do1 = mem[rad1];

  always #5 rck = ~rck;

  dpr16x4_reader #(.ERR_CLR_ON_FLUSH(1'b1)) dut (
    .rck(rck), .rst_n(rst_n), .wr_ptr(wr_ptr), .rad(rad), .ram_do(ram_do),
    .rd_ptr(rd_ptr), .q(q), .q_valid(q_valid), .q_ready(q_ready), .flush(flush),
    .level(level), .empty(empty), .ovf_err(ovf_err)
  );

  dpr16x4_reader #(.ERR_CLR_ON_FLUSH(1'b0)) dut_keep (
    .rck(rck), .rst_n(rst_n), .wr_ptr(wr_ptr), .rad(rad1), .ram_do(ram_do1),
    .rd_ptr(rd_ptr1), .q(q1), .q_valid(q_valid1), .q_ready(q_ready), .flush(flush),
    .level(level1), .empty(empty1), .ovf_err(ovf_err1)
  );

  function automatic logic [3:0] sdat(input int i);
    return 4'((i * 7 + 3) % 16);
  endfunction

  task automatic step();
    @(posedge rck);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_ptr = '0; flush = 1'b0; q_ready = 1'b0;
    repeat (2) @(posedge rck);
    @(negedge rck);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_ptr = '0; flush = 1'b0; q_ready = 1'b0;
    repeat (2) @(posedge rck);
    #1;
    checks++; if (rd_ptr !== 5'd0) begin errors++; $display("FAIL rst_rd_ptr got %0d exp 0", rd_ptr); end
    checks++; if (rad !== 4'd0) begin errors++; $display("FAIL rst_rad got %0d exp 0", rad); end
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL rst_q got %h exp 0", q); end
    checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL rst_q_valid got %b exp 0", q_valid); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", ovf_err); end
    checks++; if (empty !== 1'b1 || level !== 5'd0) begin errors++; $display("FAIL rst_empty got %b/%0d exp 1/0", empty, level); end
    @(negedge rck);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    mem[0] = 4'h3; mem[1] = 4'h7; mem[2] = 4'hB;
    q_ready = 1'b1; wr_ptr = 5'd3;
    #1;
    checks++; if (level !== 5'd3) begin errors++; $display("FAIL basic_level got %0d exp 3", level); end
    step();
    checks++; if (q !== 4'h3 || q_valid !== 1'b1) begin errors++; $display("FAIL basic_w0 got %h/%b exp 3/1", q, q_valid); end
    step();
    checks++; if (q !== 4'h7 || q_valid !== 1'b1) begin errors++; $display("FAIL basic_w1 got %h/%b exp 7/1", q, q_valid); end
    step();
    checks++; if (q !== 4'hB || q_valid !== 1'b1) begin errors++; $display("FAIL basic_w2 got %h/%b exp B/1", q, q_valid); end
    step();
    checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", q_valid); end
    checks++; if (rd_ptr !== 5'd3 || empty !== 1'b1) begin errors++; $display("FAIL basic_ptr got %0d/%b exp 3/1", rd_ptr, empty); end
  endtask

  task automatic test_backpressure();
    do_reset();
    mem[0] = 4'h5; mem[1] = 4'hA;
    q_ready = 1'b0; wr_ptr = 5'd2;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (q !== 4'h5 || q_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d got %h/%b exp 5/1", c, q, q_valid); end
      checks++; if (rd_ptr !== 5'd1 || level !== 5'd1) begin errors++; $display("FAIL bp_ptr%0d got %0d/%0d exp 1/1", c, rd_ptr, level); end
    end
    q_ready = 1'b1;
    step();
    checks++; if (q !== 4'hA || q_valid !== 1'b1 || rd_ptr !== 5'd2) begin errors++; $display("FAIL bp_next got %h/%b/%0d exp A/1/2", q, q_valid, rd_ptr); end
    step();
    checks++; if (q_valid !== 1'b0 || q !== 4'hA) begin errors++; $display("FAIL bp_drop got %h/%b exp A/0", q, q_valid); end
  endtask

  task automatic test_stream();
    do_reset();
    q_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mem[wr_ptr[3:0]] = sdat(i);
      wr_ptr = wr_ptr + 5'd1;
      step();
      checks++; if (q !== sdat(i) || q_valid !== 1'b1) begin errors++; $display("FAIL stream_q%0d got %h/%b exp %h/1", i, q, q_valid, sdat(i)); end
      checks++; if (rd_ptr !== 5'(i + 1)) begin errors++; $display("FAIL stream_ptr%0d got %0d exp %0d", i, rd_ptr, i + 1); end
      checks++; if (rad !== 4'((i + 1) % 16)) begin errors++; $display("FAIL stream_rad%0d got %0d exp %0d", i, rad, (i + 1) % 16); end
    end
    step();
    checks++; if (q_valid !== 1'b0 || rd_ptr !== 5'd20 || empty !== 1'b1) begin errors++; $display("FAIL stream_end got %b/%0d/%b exp 0/20/1", q_valid, rd_ptr, empty); end
  endtask

  task automatic test_wrap32();
    flush = 1'b1; wr_ptr = 5'd30;
    step();
    flush = 1'b0;
    checks++; if (rd_ptr !== 5'd30 || q_valid !== 1'b0 || ovf_err !== 1'b0) begin errors++; $display("FAIL wrap_flush got %0d/%b/%b exp 30/0/0", rd_ptr, q_valid, ovf_err); end
    mem[14] = 4'h1; mem[15] = 4'h2; mem[0] = 4'h4; mem[1] = 4'h8;
    q_ready = 1'b0; wr_ptr = 5'd2;
    #1;
    checks++; if (level !== 5'd4 || empty !== 1'b0) begin errors++; $display("FAIL wrap_level got %0d/%b exp 4/0", level, empty); end
    q_ready = 1'b1;
    step();
    checks++; if (q !== 4'h1 || rd_ptr !== 5'd31) begin errors++; $display("FAIL wrap_w0 got %h/%0d exp 1/31", q, rd_ptr); end
    step();
    checks++; if (q !== 4'h2 || rd_ptr !== 5'd0 || rad !== 4'd0) begin errors++; $display("FAIL wrap_w1 got %h/%0d/%0d exp 2/0/0", q, rd_ptr, rad); end
    step();
    checks++; if (q !== 4'h4 || rd_ptr !== 5'd1 || level !== 5'd1) begin errors++; $display("FAIL wrap_w2 got %h/%0d/%0d exp 4/1/1", q, rd_ptr, level); end
    step();
    checks++; if (q !== 4'h8 || rd_ptr !== 5'd2 || empty !== 1'b1) begin errors++; $display("FAIL wrap_w3 got %h/%0d/%b exp 8/2/1", q, rd_ptr, empty); end
  endtask

  task automatic test_overflow();
    do_reset();
    q_ready = 1'b0; wr_ptr = 5'd17;
    #1;
    checks++; if (level !== 5'd17 || ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_pre got %0d/%b exp 17/0", level, ovf_err); end
    step();
    checks++; if (ovf_err !== 1'b1 || ovf_err1 !== 1'b1) begin errors++; $display("FAIL ovf_set got %b/%b exp 1/1", ovf_err, ovf_err1); end
    checks++; if (rd_ptr !== 5'd1 || q_valid !== 1'b1) begin errors++; $display("FAIL ovf_read got %0d/%b exp 1/1", rd_ptr, q_valid); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (rd_ptr !== 5'd17 || q_valid !== 1'b0) begin errors++; $display("FAIL ovf_flush got %0d/%b exp 17/0", rd_ptr, q_valid); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", ovf_err); end
    checks++; if (ovf_err1 !== 1'b1 || rd_ptr1 !== 5'd17) begin errors++; $display("FAIL ovf_keep got %b/%0d exp 1/17", ovf_err1, rd_ptr1); end
  endtask

  task automatic test_flush_load();
    do_reset();
    mem[0] = 4'h6; mem[1] = 4'h9;
    q_ready = 1'b1; wr_ptr = 5'd2;
    step();
    checks++; if (q !== 4'h6 || rd_ptr !== 5'd1) begin errors++; $display("FAIL fl_pre got %h/%0d exp 6/1", q, rd_ptr); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (q_valid !== 1'b0 || q !== 4'h6 || rd_ptr !== 5'd2) begin errors++; $display("FAIL fl_noload got %b/%h/%0d exp 0/6/2", q_valid, q, rd_ptr); end
    step();
    checks++; if (q_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL fl_after got %b/%b exp 0/1", q_valid, empty); end
  endtask

  task automatic test_async_reset();
    do_reset();
    mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h3;
    q_ready = 1'b1; wr_ptr = 5'd3;
    step();
    step();
    checks++; if (q !== 4'h2 || rd_ptr !== 5'd2) begin errors++; $display("FAIL ar_pre got %h/%0d exp 2/2", q, rd_ptr); end
    #2;
    rst_n = 1'b0; wr_ptr = '0;
    #1;
    checks++; if (q !== 4'h0 || q_valid !== 1'b0) begin errors++; $display("FAIL ar_q got %h/%b exp 0/0", q, q_valid); end
    checks++; if (rd_ptr !== 5'd0 || rad !== 4'd0) begin errors++; $display("FAIL ar_ptr got %0d/%0d exp 0/0", rd_ptr, rad); end
    mem[0] = 4'hC; wr_ptr = 5'd1;
    @(negedge rck);
    rst_n = 1'b1;
    step();
    checks++; if (q !== 4'hC || q_valid !== 1'b1 || rd_ptr !== 5'd1) begin errors++; $display("FAIL ar_first got %h/%b/%0d exp C/1/1", q, q_valid, rd_ptr); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    test_reset();
    test_basic();
    test_backpressure();
    test_stream();
    test_wrap32();
    test_overflow();
    test_flush_load();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
